// File: rtl/acq_sequencer_if.sv
// Connects the acquisition sequencer to its command source and to the
// write port of the sample buffer.
//   Commands in : ArmCmd, AbortCmd, ReadoutDone (one-cycle pulses), Trigger
//                 (level, already synchronous), PreTrigCount, PostTrigCount
//   Status out  : WriteEnable, WriteAddress, TriggerAddress, Armed, AcqDone,
//                 AutoTriggered, State
// master = command/readout side, slave = the sequencer itself.
interface acq_sequencer_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  ArmCmd;
    logic                  AbortCmd;
    logic                  Trigger;
    logic [ADDR_WIDTH-1:0] PreTrigCount;
    logic [ADDR_WIDTH-1:0] PostTrigCount;
    logic                  ReadoutDone;
    logic                  WriteEnable;
    logic [ADDR_WIDTH-1:0] WriteAddress;
    logic [ADDR_WIDTH-1:0] TriggerAddress;
    logic                  Armed;
    logic                  AcqDone;
    logic                  AutoTriggered;
    logic [2:0]            State;

    modport master (
        output ArmCmd, AbortCmd, Trigger, PreTrigCount, PostTrigCount, ReadoutDone,
        input  WriteEnable, WriteAddress, TriggerAddress, Armed, AcqDone,
               AutoTriggered, State
    );

    modport slave (
        input  ArmCmd, AbortCmd, Trigger, PreTrigCount, PostTrigCount, ReadoutDone,
        output WriteEnable, WriteAddress, TriggerAddress, Armed, AcqDone,
               AutoTriggered, State
    );
endinterface

// File: rtl/acq_sequencer.sv
// Acquisition sequencer: arm, pre-trigger fill, wait for trigger, post-trigger
// capture, then hold the buffer until readout is finished.
// Drives the write side of a circular sample buffer and records the address
// written in the trigger cycle.
//   Clock, Reset : sample clock, synchronous active-high reset
//   bus (slave)  : commands in, buffer write strobe/address and status out
// Optional build macro ACQ_AUTO_TRIGGER_EN: forces a trigger after
// AUTO_TIMEOUT cycles in ARMED and flags it on AutoTriggered.
// All outputs come straight from registers. WriteEnable/WriteAddress describe
// the sample being written during the current cycle; Trigger sampled at the
// end of a cycle marks that cycle's sample as the trigger sample.
module acq_sequencer #(
    parameter int ADDR_WIDTH   = 10,
    parameter int AUTO_TIMEOUT = 1000000
) (
    input  logic            Clock,
    input  logic            Reset,
    acq_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRETRIG  = 3'd1,
        ARMED    = 3'd2,
        POSTTRIG = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ONE = 1;

    state_t                state, state_n;
    logic                  we, we_n, armed, armed_n, done, done_n, autot, autot_n;
    logic [ADDR_WIDTH-1:0] wa, wa_n, ta, ta_n, p, p_n, q, q_n, cnt, cnt_n;
    logic                  fire_auto;

`ifdef ACQ_AUTO_TRIGGER_EN
    localparam int TW = $clog2(AUTO_TIMEOUT) + 1;
    logic [TW-1:0] tcnt;

    // Held at zero outside ARMED, so it starts from zero on every entry.
    always_ff @(posedge Clock) begin
        if (Reset || state != ARMED) tcnt <= '0;
        else                         tcnt <= tcnt + 1'b1;
    end

    assign fire_auto = we && (tcnt >= TW'(AUTO_TIMEOUT - 1));
`else
    // No timeout in this build: ARMED waits for a real trigger forever.
    assign fire_auto = (AUTO_TIMEOUT < 0);
`endif

    always_comb begin
        state_n = state;
        we_n    = we;
        armed_n = armed;
        done_n  = done;
        autot_n = autot;
        wa_n    = wa;
        ta_n    = ta;
        p_n     = p;
        q_n     = q;
        cnt_n   = cnt;
        if (bus.AbortCmd) begin
            state_n = IDLE;
            we_n    = 1'b0;
            armed_n = 1'b0;
            done_n  = 1'b0;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    we_n = 1'b0;
                    if (bus.ArmCmd) begin
                        p_n     = bus.PreTrigCount;
                        q_n     = bus.PostTrigCount;
                        wa_n    = '0;
                        cnt_n   = '0;
                        autot_n = 1'b0;
                        if (bus.PreTrigCount != '0) begin
                            state_n = PRETRIG;
                        end else begin
                            state_n = ARMED;
                            armed_n = 1'b1;
                        end
                    end
                end
                PRETRIG: begin
                    // First PRETRIG cycle is the set-up cycle (we=0) that
                    // gives address 0 one cycle after the arm edge.
                    we_n = 1'b1;
                    if (cnt == p) begin
                        state_n = ARMED;
                        armed_n = 1'b1;
                        wa_n    = wa + ONE;
                    end else begin
                        cnt_n = cnt + ONE;
                        if (we) wa_n = wa + ONE;
                    end
                end
                ARMED: begin
                    we_n = 1'b1;
                    // Only a cycle that actually writes a sample can be the
                    // trigger sample (matters for the P=0 entry cycle).
                    if (we) begin
                        wa_n = wa + ONE;
                        if (bus.Trigger || fire_auto) begin
                            ta_n    = wa;
                            autot_n = !bus.Trigger;
                            cnt_n   = '0;
                            armed_n = 1'b0;
                            if (q != '0) begin
                                state_n = POSTTRIG;
                            end else begin
                                state_n = DONE;
                                we_n    = 1'b0;
                                done_n  = 1'b1;
                            end
                        end
                    end
                end
                POSTTRIG: begin
                    wa_n = wa + ONE;
                    if (cnt + ONE == q) begin
                        state_n = DONE;
                        we_n    = 1'b0;
                        done_n  = 1'b1;
                        cnt_n   = '0;
                    end else begin
                        we_n  = 1'b1;
                        cnt_n = cnt + ONE;
                    end
                end
                DONE: begin
                    we_n = 1'b0;
                    if (bus.ReadoutDone) begin
                        state_n = IDLE;
                        done_n  = 1'b0;
                    end
                end
                default: begin
                    state_n = IDLE;
                    we_n    = 1'b0;
                    armed_n = 1'b0;
                    done_n  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
            we    <= 1'b0;
            armed <= 1'b0;
            done  <= 1'b0;
            autot <= 1'b0;
            wa    <= '0;
            ta    <= '0;
            p     <= '0;
            q     <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            we    <= we_n;
            armed <= armed_n;
            done  <= done_n;
            autot <= autot_n;
            wa    <= wa_n;
            ta    <= ta_n;
            p     <= p_n;
            q     <= q_n;
            cnt   <= cnt_n;
        end
    end

    assign bus.WriteEnable    = we;
    assign bus.WriteAddress   = wa;
    assign bus.TriggerAddress = ta;
    assign bus.Armed          = armed;
    assign bus.AcqDone        = done;
    assign bus.AutoTriggered  = autot;
    assign bus.State          = state;
endmodule

// File: tb/tb_acq_sequencer.sv
// Directed bench for acq_sequencer: a 10-bit instance driven from a vector
// table plus hand-written sequences, and a 4-bit instance for address wrap.
module tb_acq_sequencer;
    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    acq_sequencer_if #(.ADDR_WIDTH(10)) bus_a ();
    acq_sequencer_if #(.ADDR_WIDTH(4))  bus_b ();

    acq_sequencer #(.ADDR_WIDTH(10), .AUTO_TIMEOUT(8)) u_a (
        .Clock(Clock), .Reset(Reset), .bus(bus_a.slave));
    acq_sequencer #(.ADDR_WIDTH(4), .AUTO_TIMEOUT(1000)) u_b (
        .Clock(Clock), .Reset(Reset), .bus(bus_b.slave));

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [2:0] st;
        logic       we;
        logic [9:0] wa;
        logic       armed;
        logic       done;
        logic [9:0] ta;
    } obs_t;

    typedef struct {
        logic [9:0] pre, post;
        logic       arm, abort, trig, rdone;
        obs_t       exp;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    function automatic obs_t obs_a();
        obs_t o;
        o.st    = bus_a.State;
        o.we    = bus_a.WriteEnable;
        o.wa    = bus_a.WriteAddress;
        o.armed = bus_a.Armed;
        o.done  = bus_a.AcqDone;
        o.ta    = bus_a.TriggerAddress;
        return o;
    endfunction

    function automatic vec_t mk(int pre, int post, bit arm, bit abort, bit trig, bit rdone,
                                int st, bit we, int wa, bit armed, bit done, int ta);
        vec_t v;
        v.pre = 10'(pre);  v.post = 10'(post);
        v.arm = arm; v.abort = abort; v.trig = trig; v.rdone = rdone;
        v.exp.st = 3'(st); v.exp.we = we; v.exp.wa = 10'(wa);
        v.exp.armed = armed; v.exp.done = done; v.exp.ta = 10'(ta);
        return v;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal;
    end

    initial begin
        int n;
        //           pre post arm abt trg rd   st we  wa arm dn ta
        // Pre=4 Post=3: trigger during PRETRIG ignored, trigger at address 9.
        tbl.push_back(mk(4, 3, 1, 0, 0, 0,   1, 0,  0, 0, 0, 0));
        tbl.push_back(mk(9, 9, 0, 0, 1, 0,   1, 1,  0, 0, 0, 0));
        tbl.push_back(mk(9, 9, 0, 0, 0, 0,   1, 1,  1, 0, 0, 0));
        tbl.push_back(mk(9, 9, 0, 0, 0, 0,   1, 1,  2, 0, 0, 0));
        tbl.push_back(mk(9, 9, 0, 0, 0, 0,   1, 1,  3, 0, 0, 0));
        tbl.push_back(mk(9, 9, 0, 0, 0, 0,   2, 1,  4, 1, 0, 0));
        tbl.push_back(mk(9, 9, 0, 0, 0, 0,   2, 1,  5, 1, 0, 0));
        tbl.push_back(mk(9, 9, 0, 0, 0, 0,   2, 1,  6, 1, 0, 0));
        tbl.push_back(mk(9, 9, 0, 0, 0, 0,   2, 1,  7, 1, 0, 0));
        tbl.push_back(mk(9, 9, 0, 0, 0, 0,   2, 1,  8, 1, 0, 0));
        tbl.push_back(mk(9, 9, 0, 0, 0, 0,   2, 1,  9, 1, 0, 0));
        tbl.push_back(mk(9, 9, 0, 0, 1, 0,   3, 1, 10, 0, 0, 9));
        tbl.push_back(mk(9, 9, 0, 0, 0, 0,   3, 1, 11, 0, 0, 9));
        tbl.push_back(mk(9, 9, 0, 0, 0, 0,   3, 1, 12, 0, 0, 9));
        tbl.push_back(mk(9, 9, 1, 0, 0, 0,   4, 0, 13, 0, 1, 9));
        tbl.push_back(mk(9, 9, 1, 0, 1, 0,   4, 0, 13, 0, 1, 9));
        tbl.push_back(mk(9, 9, 0, 0, 0, 1,   0, 0, 13, 0, 0, 9));
        // Pre=0 Post=0 with Trigger held: straight to ARMED, one write at 0.
        tbl.push_back(mk(0, 0, 1, 0, 1, 0,   2, 0,  0, 1, 0, 9));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0,   2, 1,  0, 1, 0, 9));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0,   4, 0,  1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,   0, 0,  1, 0, 0, 0));
        // Pre=2 Post=4, abort in POSTTRIG together with ReadoutDone.
        tbl.push_back(mk(2, 4, 1, 0, 0, 0,   1, 0,  0, 0, 0, 0));
        tbl.push_back(mk(2, 4, 0, 0, 0, 0,   1, 1,  0, 0, 0, 0));
        tbl.push_back(mk(2, 4, 0, 0, 0, 0,   1, 1,  1, 0, 0, 0));
        tbl.push_back(mk(2, 4, 0, 0, 0, 0,   2, 1,  2, 1, 0, 0));
        tbl.push_back(mk(2, 4, 0, 0, 1, 0,   3, 1,  3, 0, 0, 2));
        tbl.push_back(mk(2, 4, 0, 0, 0, 0,   3, 1,  4, 0, 0, 2));
        tbl.push_back(mk(2, 4, 0, 1, 0, 1,   0, 0,  4, 0, 0, 2));
        tbl.push_back(mk(2, 4, 0, 0, 0, 0,   0, 0,  4, 0, 0, 2));
        // Abort beats ArmCmd in IDLE.
        tbl.push_back(mk(2, 4, 1, 1, 0, 0,   0, 0,  4, 0, 0, 2));

        Reset = 1'b1;
        bus_a.ArmCmd = 0; bus_a.AbortCmd = 0; bus_a.Trigger = 0; bus_a.ReadoutDone = 0;
        bus_a.PreTrigCount = '0; bus_a.PostTrigCount = '0;
        bus_b.ArmCmd = 0; bus_b.AbortCmd = 0; bus_b.Trigger = 0; bus_b.ReadoutDone = 0;
        bus_b.PreTrigCount = '0; bus_b.PostTrigCount = '0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        cyc();
        chk("reset_a", 32'(obs_a()), 32'd0);
        chk("reset_a_auto", 32'(bus_a.AutoTriggered), 32'd0);
        chk("reset_b", 32'({bus_b.State, bus_b.WriteEnable, bus_b.WriteAddress,
                            bus_b.TriggerAddress, bus_b.Armed, bus_b.AcqDone}), 32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            bus_a.PreTrigCount  = tbl[i].pre;
            bus_a.PostTrigCount = tbl[i].post;
            bus_a.ArmCmd        = tbl[i].arm;
            bus_a.AbortCmd      = tbl[i].abort;
            bus_a.Trigger       = tbl[i].trig;
            bus_a.ReadoutDone   = tbl[i].rdone;
            cyc();
            chk($sformatf("row%0d", i), 32'(obs_a()), 32'(tbl[i].exp));
        end
        bus_a.ArmCmd = 0; bus_a.AbortCmd = 0; bus_a.Trigger = 0; bus_a.ReadoutDone = 0;

        // 4-bit buffer: Pre=14 Post=5, trigger in first ARMED cycle, wrap.
        bus_b.PreTrigCount = 4'd14; bus_b.PostTrigCount = 4'd5; bus_b.ArmCmd = 1;
        cyc();
        bus_b.ArmCmd = 0;
        chk("b_pretrig", 32'(bus_b.State), 32'd1);
        n = 0;
        while (bus_b.State != 3'd2 && n < 40) begin
            cyc();
            n++;
        end
        chk("b_pre_len", 32'(n), 32'd15);
        chk("b_armed_addr", 32'(bus_b.WriteAddress), 32'd14);
        bus_b.Trigger = 1;
        cyc();
        bus_b.Trigger = 0;
        chk("b_trig_addr", 32'(bus_b.TriggerAddress), 32'd14);
        chk("b_post0", 32'({bus_b.State, bus_b.WriteEnable, bus_b.WriteAddress}),
            32'({3'd3, 1'b1, 4'd15}));
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk($sformatf("b_wrap%0d", k), 32'({bus_b.WriteEnable, bus_b.WriteAddress}),
                32'({1'b1, 4'(k)}));
        end
        cyc();
        chk("b_done", 32'({bus_b.State, bus_b.WriteEnable, bus_b.AcqDone, bus_b.WriteAddress}),
            32'({3'd4, 1'b0, 1'b1, 4'd4}));
        bus_b.ReadoutDone = 1;
        cyc();
        bus_b.ReadoutDone = 0;
        chk("b_idle", 32'(bus_b.State), 32'd0);

        // Timeout behaviour on the 10-bit instance: Pre=2 Post=0, no Trigger.
        bus_a.PreTrigCount = 10'd2; bus_a.PostTrigCount = 10'd0; bus_a.ArmCmd = 1;
        cyc();
        bus_a.ArmCmd = 0;
`ifdef ACQ_AUTO_TRIGGER_EN
        repeat (10) cyc();
        chk("auto_wait", 32'({bus_a.State, bus_a.WriteAddress, bus_a.AutoTriggered}),
            32'({3'd2, 10'd9, 1'b0}));
        cyc();
        chk("auto_fire", 32'({bus_a.State, bus_a.TriggerAddress, bus_a.AutoTriggered, bus_a.AcqDone}),
            32'({3'd4, 10'd9, 1'b1, 1'b1}));
        bus_a.ReadoutDone = 1;
        cyc();
        bus_a.ReadoutDone = 0;
        chk("auto_hold", 32'({bus_a.State, bus_a.AutoTriggered}), 32'({3'd0, 1'b1}));
        bus_a.ArmCmd = 1;
        cyc();
        bus_a.ArmCmd = 0;
        chk("auto_clear", 32'(bus_a.AutoTriggered), 32'd0);
`else
        repeat (30) cyc();
        chk("no_auto", 32'({bus_a.State, bus_a.WriteAddress, bus_a.AutoTriggered}),
            32'({3'd2, 10'd29, 1'b0}));
`endif
        bus_a.AbortCmd = 1;
        cyc();
        bus_a.AbortCmd = 0;
        chk("abort_armed", 32'({bus_a.State, bus_a.WriteEnable, bus_a.Armed}), 32'd0);

        // Reset in the middle of an acquisition.
        bus_a.PreTrigCount = 10'd3; bus_a.PostTrigCount = 10'd3; bus_a.ArmCmd = 1;
        cyc();
        bus_a.ArmCmd = 0;
        bus_a.Trigger = 1;
        repeat (6) cyc();
        bus_a.Trigger = 0;
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        chk("mid_reset", 32'(obs_a()), 32'd0);
        chk("mid_reset_auto", 32'(bus_a.AutoTriggered), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/acq_sequencer.md
Name: acq_sequencer

Overview:
- Sequences one acquisition: arm, pre-trigger fill, wait for trigger, post-trigger capture, hand-off to readout.
- Drives the write side of the circular sample buffer (WriteEnable, WriteAddress) and records the buffer address at which the trigger landed.
- Sits between the host command decoder (Arm/Abort/ReadoutDone pulses) and the sample-buffer write port.
- Replaces the one-shot armed/trigger latch with a full, re-armable state machine.

Parameters:
- ADDR_WIDTH, 10, sample-buffer address width; buffer depth = 2^ADDR_WIDTH.
- AUTO_TIMEOUT, 1000000, cycles spent in ARMED before a forced trigger. Used only with ACQ_AUTO_TRIGGER_EN.

Ports:
- Clock  input  1  sample clock.
- Reset  input  1  synchronous, active-high.
- ArmCmd  input  1  one-cycle pulse: start an acquisition.
- AbortCmd  input  1  one-cycle pulse: abandon the acquisition.
- Trigger  input  1  trigger level, already synchronised to Clock.
- PreTrigCount  input  ADDR_WIDTH  samples to write before triggers are accepted.
- PostTrigCount  input  ADDR_WIDTH  samples to write after the trigger sample.
- ReadoutDone  input  1  one-cycle pulse: readout has finished, release the buffer.
- WriteEnable  output  1  buffer write strobe.
- WriteAddress  output  ADDR_WIDTH  buffer write address.
- TriggerAddress  output  ADDR_WIDTH  address of the sample written in the trigger cycle.
- Armed  output  1  high while in ARMED.
- AcqDone  output  1  high while in DONE.
- AutoTriggered  output  1  the last trigger was forced by timeout.
- State  output  3  current state encoding, for debug/status.

Behaviour:
- Interface: reset Reset, synchronous, active-high; clock Clock.
- All outputs are registered.
- Reset values:
  - State is IDLE.
  - WriteEnable, Armed, AcqDone and AutoTriggered are 0.
  - WriteAddress and TriggerAddress are 0.
  - Internal counters are 0.
- State encodings: IDLE=0, PRETRIG=1, ARMED=2, POSTTRIG=3, DONE=4.
- IDLE:
  - WriteEnable=0.
  - ArmCmd latches PreTrigCount into P and PostTrigCount into Q, clears WriteAddress to 0 and clears the counter.
  - Next state is PRETRIG if P!=0, otherwise ARMED.
  - Trigger and ReadoutDone are ignored.
- Arm latency: ArmCmd sampled at edge n gives WriteEnable=1 with WriteAddress=0 after edge n+1.
- PRETRIG:
  - WriteEnable=1; WriteAddress increments by 1 every cycle, wrapping modulo 2^ADDR_WIDTH.
  - Writes addresses 0..P-1, then moves to ARMED; the first ARMED cycle writes address P.
  - Trigger is ignored.
- ARMED:
  - Armed=1, WriteEnable=1, address keeps incrementing and wrapping.
  - Trigger=1 at an edge, with current write address A, causes: TriggerAddress<=A, AutoTriggered<=0, counter cleared.
  - Next state is POSTTRIG if Q!=0, otherwise DONE.
- POSTTRIG:
  - WriteEnable=1, Armed=0.
  - Writes A+1..A+Q (mod depth), then moves to DONE.
  - WriteEnable is 0 in the first DONE cycle.
  - Trigger is ignored.
- DONE:
  - WriteEnable=0, AcqDone=1; WriteAddress holds the last address + 1.
  - ReadoutDone moves to IDLE; AcqDone drops the next cycle.
  - ArmCmd is ignored.
- AbortCmd:
  - Any state goes to IDLE at the next edge.
  - WriteEnable, Armed and AcqDone drop at that edge; TriggerAddress is held.
- Priority when events coincide: Reset > AbortCmd > ArmCmd/Trigger/ReadoutDone.
- ArmCmd outside IDLE is ignored; no re-arm while busy.
- Changes to PreTrigCount/PostTrigCount after arming have no effect until the next ArmCmd.
- P+Q+1 > depth is allowed and overwrites the oldest samples; no error is flagged, and the software window is the caller's responsibility.
- Reset mid-acquisition returns every register to its reset value at that edge.

Optional Feature:
- Macro: ACQ_AUTO_TRIGGER_EN.
- Defined:
  - A timeout counter clears on entering ARMED and increments each ARMED cycle.
  - When it reaches AUTO_TIMEOUT-1 with no Trigger, the block forces a trigger: identical to a real trigger, but AutoTriggered<=1.
  - A real Trigger in that same cycle wins (AutoTriggered=0).
- Undefined:
  - ARMED waits indefinitely.
  - AutoTriggered is tied 0 and the timeout counter is not built.
- Both builds: AutoTriggered is cleared by ArmCmd.

Test Plan:
- Reset held 3 cycles, then released → State=0, WriteEnable=0, AcqDone=0, all addresses 0.
- Pre=4, Post=3, ArmCmd at edge 10, Trigger at edge 20 →
  - WriteEnable high from cycle 11.
  - Armed from cycle 15, at address 4.
  - TriggerAddress=9.
  - Writes 10..12; WriteEnable low and AcqDone high from cycle 24.
  - ReadoutDone → IDLE.
- Pre=0, Post=0, ArmCmd then Trigger held high → IDLE→ARMED directly; exactly one sample is written at address 0; then DONE.
- ADDR_WIDTH=4, Pre=14, Post=5, trigger in the first ARMED cycle → TriggerAddress=14; write addresses 15,0,1,2,3 (wrap); DONE.
- AbortCmd in POSTTRIG coinciding with ReadoutDone, and ArmCmd in DONE →
  - Abort returns to IDLE next edge, WriteEnable low.
  - ArmCmd in DONE causes no state change.
  - Trigger during PRETRIG is ignored.
- With ACQ_AUTO_TRIGGER_EN, AUTO_TIMEOUT=8, Pre=2, no Trigger → forced trigger on the 8th ARMED cycle; AutoTriggered=1; the next ArmCmd clears it.
